audio_rec_ctrl: RTL and testbench
=================================

# audio_rec_ctrl

Record/playback sequencer between the codec sample path and the external 16-bit SRAM. It waits for codec initialisation, then stores ADC samples to SRAM on record and streams them back to the DAC on play. Playback supports fast (sample skip) and slow (sample repeat) speeds. It drives the SRAM bus as split write-data/read-data/output-enable; the top level builds the tristate.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample / SRAM word width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- init_done  in  1  codec I2C configuration complete, level
- play_btn, stop_btn, record_btn  in  1 each  debounced single-cycle active-high pulses
- speed_sw  in  4  [3]=0 fast, [3]=1 slow; factor F = speed_sw[2:0]+1 (1..8)
- adc_valid  in  1  one-cycle pulse; adc_data is valid with it
- adc_data  in  DATA_W  captured ADC sample
- dac_req  in  1  one-cycle pulse; DAC serializer requests the next sample
- dac_data  out  DATA_W  sample to DAC, held between updates
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  data to drive on DQ
- sram_dq_oe  out  1  top drives DQ when 1
- sram_rdata  in  DATA_W  DQ input
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes
- state  out  3  0 INIT, 1 IDLE, 2 RECORD, 3 PLAY, 4 PAUSE
- end_addr  out  ADDR_W  number of recorded words
- overrun  out  1  one-cycle pulse: adc_valid/dac_req arrived while an SRAM access was in progress

## Operation
- Reset values: state=INIT, dac_data=0, sram_addr=0, sram_wdata=0, sram_dq_oe=0, all SRAM strobes 1, end_addr=0, overrun=0, internal address and repeat counters 0.
- INIT -> IDLE when init_done=1. Buttons are ignored in INIT.
- Button priority in one cycle: stop > record > play.
- IDLE: record_btn -> RECORD, address=0. play_btn -> PLAY, address=0, repeat=0; if end_addr=0, stay IDLE.
- RECORD: each adc_valid starts a write of adc_data at address, then address+1. stop_btn -> IDLE, end_addr=address. If a write lands at address all-ones -> IDLE, end_addr=all-ones. Play and record buttons are ignored.
- PLAY: each dac_req starts a read at address; the result loads dac_data.
  - Fast: address += F after each read.
  - Slow: address holds until F reads are issued (repeat counter 0..F-1), then +1.
  - If the next address is >= end_addr: -> IDLE, address=0.
- PLAY: play_btn -> PAUSE; stop_btn -> IDLE. PAUSE: play_btn -> PLAY, resuming at the held address; stop_btn -> IDLE. dac_data holds in PAUSE and IDLE.
- speed_sw is sampled at each advance, not latched at play start.
- Accesses are not queued. A request arriving while an access is busy is dropped and overrun pulses.
- Stop mid-access: the access completes, then the state changes. end_addr counts only completed writes.
- sram_ub_n=sram_lb_n=0 whenever sram_ce_n=0.

## Timing
- Write, 2 cycles after adc_valid is registered:
  - W1: ce_n=0, we_n=0, dq_oe=1, addr/wdata valid.
  - W2: we_n=1, dq_oe=1, ce_n=0.
  - Next cycle: strobes idle, address increments.
- Read, 3 cycles:
  - R1: ce_n=0, oe_n=0, dq_oe=0.
  - R2: hold.
  - R3: sram_rdata captured into dac_data.
- dac_data is updated on the clock edge 3 cycles after the dac_req edge.
- A new request is accepted on the cycle after W2/R3 (1 cycle idle gap).
- state changes are registered, so they appear 1 cycle after the button pulse.

## Configuration
- PLAY_LOOP_EN defined: when playback reaches end_addr, address wraps to 0 and play continues until stop_btn or play_btn.
- Without it: playback returns to IDLE at end_addr as described.

## Test plan
- Reset released with init_done=0 for 10 cycles, then 1 -> state stays 0 until init_done, then becomes 1 one cycle later; all SRAM strobes stay 1.
- Record 5 samples 0x1111..0x5555, then stop_btn -> writes at addresses 0..4 with we_n low for exactly 1 cycle each; end_addr=5; state=IDLE.
- Play at speed_sw=0 -> dac_data = 0x1111..0x5555, each 3 cycles after its dac_req; returns to IDLE after the 5th read, or wraps to 0x1111 with PLAY_LOOP_EN.
- speed_sw=4'b0001 (fast 2x) -> reads at 0, 2, 4, then IDLE. speed_sw=4'b1001 (slow 2x) -> reads at 0, 0, 1, 1, ...
- PAUSE at address 2, wait 100 cycles with dac_req pulses, then play_btn -> no SRAM reads during the pause; the next read is at address 2.
- adc_valid on W1+1 -> sample dropped, overrun=1 for 1 cycle, address advances once only; stop_btn and play_btn in the same cycle -> stop wins; reset asserted mid-write -> strobes return to 1 asynchronously.

Source files
------------

// File: rtl/audio_rec_if.sv
// audio_rec_if: codec sample path, SRAM bus and status signals of audio_rec_ctrl.
interface audio_rec_if #(parameter int ADDR_W = 20, parameter int DATA_W = 16);
  logic              i_init_done;
  logic              i_play_btn;
  logic              i_stop_btn;
  logic              i_record_btn;
  logic [3:0]        i_speed_sw;
  logic              i_adc_valid;
  logic [DATA_W-1:0] i_adc_data;
  logic              i_dac_req;
  logic [DATA_W-1:0] o_dac_data;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_sram_wdata;
  logic              o_sram_dq_oe;
  logic [DATA_W-1:0] i_sram_rdata;
  logic              o_sram_ce_n;
  logic              o_sram_oe_n;
  logic              o_sram_we_n;
  logic              o_sram_ub_n;
  logic              o_sram_lb_n;
  logic [2:0]        o_state;
  logic [ADDR_W-1:0] o_end_addr;
  logic              o_overrun;
  modport master (
    output i_init_done, i_play_btn, i_stop_btn, i_record_btn, i_speed_sw,
           i_adc_valid, i_adc_data, i_dac_req, i_sram_rdata,
    input  o_dac_data, o_sram_addr, o_sram_wdata, o_sram_dq_oe, o_sram_ce_n,
           o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_state,
           o_end_addr, o_overrun
  );
  modport slave (
    input  i_init_done, i_play_btn, i_stop_btn, i_record_btn, i_speed_sw,
           i_adc_valid, i_adc_data, i_dac_req, i_sram_rdata,
    output o_dac_data, o_sram_addr, o_sram_wdata, o_sram_dq_oe, o_sram_ce_n,
           o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_state,
           o_end_addr, o_overrun
  );
endinterface

// File: rtl/audio_rec_ctrl.sv
// audio_rec_ctrl: record/playback sequencer between codec samples and a 16-bit SRAM.
// Define PLAY_LOOP_EN to wrap playback to address 0 at end_addr instead of returning to IDLE.
module audio_rec_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  audio_rec_if.slave bus
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REC, S_PLAY, S_PAUSE} state_t;
  typedef enum logic [2:0] {A_IDLE, A_W1, A_W2, A_R1, A_R2, A_R3} acc_t;
  state_t            r_state, w_state;
  acc_t              r_acc, w_acc;
  logic [ADDR_W-1:0] r_addr, w_addr, r_end, w_end;
  logic [2:0]        r_rep, w_rep;
  logic [DATA_W-1:0] r_dac, w_dac, r_wdata, w_wdata;
  logic              r_stop_p, w_stop_p, r_play_p, w_play_p, r_ovr, w_ovr;
  logic              w_busy, w_stop, w_play;
  logic [2:0]        w_f1;
  logic [ADDR_W:0]   w_step, w_next;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_INIT;
      r_acc    <= A_IDLE;
      r_addr   <= '0;
      r_end    <= '0;
      r_rep    <= '0;
      r_dac    <= '0;
      r_wdata  <= '0;
      r_stop_p <= 1'b0;
      r_play_p <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_acc    <= w_acc;
      r_addr   <= w_addr;
      r_end    <= w_end;
      r_rep    <= w_rep;
      r_dac    <= w_dac;
      r_wdata  <= w_wdata;
      r_stop_p <= w_stop_p;
      r_play_p <= w_play_p;
      r_ovr    <= w_ovr;
    end

  // Buttons seen during an access are held and applied once the access has finished.
  always_comb begin
    w_busy   = r_acc != A_IDLE;
    w_stop   = bus.i_stop_btn | r_stop_p;
    w_play   = bus.i_play_btn | r_play_p;
    w_stop_p = w_busy & w_stop;
    w_play_p = w_busy & w_play;
    w_ovr    = w_busy & (bus.i_adc_valid | bus.i_dac_req);
    w_f1     = bus.i_speed_sw[2:0];
    w_step   = bus.i_speed_sw[3] ? (ADDR_W+1)'(r_rep == w_f1) : (ADDR_W+1)'(w_f1) + (ADDR_W+1)'(1);
    w_next   = {1'b0, r_addr} + w_step;
    w_state  = r_state;
    w_acc    = r_acc;
    w_addr   = r_addr;
    w_end    = r_end;
    w_rep    = r_rep;
    w_dac    = r_dac;
    w_wdata  = r_wdata;
    case (r_acc)
      A_W1: w_acc = A_W2;
      A_W2: begin
        w_acc  = A_IDLE;
        w_addr = r_addr + 1'b1;
        if (&r_addr) begin
          w_state = S_IDLE;
          w_end   = r_addr;
        end
      end
      A_R1: w_acc = A_R2;
      A_R2: w_acc = A_R3;
      A_R3: begin
        w_acc = A_IDLE;
        w_dac = bus.i_sram_rdata;
        w_rep = (bus.i_speed_sw[3] && r_rep != w_f1) ? r_rep + 3'd1 : 3'd0;
        if (w_next >= {1'b0, r_end}) begin
          w_addr = '0;
`ifdef PLAY_LOOP_EN
          w_state = r_state;
`else
          w_state = S_IDLE;
`endif
        end else
          w_addr = w_next[ADDR_W-1:0];
      end
      default:
        case (r_state)
          S_INIT: w_state = bus.i_init_done ? S_IDLE : S_INIT;
          S_IDLE:
            if (!bus.i_stop_btn && bus.i_record_btn) begin
              w_state = S_REC;
              w_addr  = '0;
            end else if (!bus.i_stop_btn && bus.i_play_btn && |r_end) begin
              w_state = S_PLAY;
              w_addr  = '0;
              w_rep   = '0;
            end
          S_REC:
            if (w_stop) begin
              w_state = S_IDLE;
              w_end   = r_addr;
            end else if (bus.i_adc_valid) begin
              w_acc   = A_W1;
              w_wdata = bus.i_adc_data;
            end
          S_PLAY: begin
            w_state = w_stop ? S_IDLE : w_play ? S_PAUSE : S_PLAY;
            w_acc   = (!w_stop && !w_play && bus.i_dac_req) ? A_R1 : A_IDLE;
          end
          S_PAUSE: w_state = w_stop ? S_IDLE : w_play ? S_PLAY : S_PAUSE;
          default: w_state = S_INIT;
        endcase
    endcase
  end

  assign bus.o_state      = r_state;
  assign bus.o_dac_data   = r_dac;
  assign bus.o_end_addr   = r_end;
  assign bus.o_overrun    = r_ovr;
  assign bus.o_sram_addr  = r_addr;
  assign bus.o_sram_wdata = r_wdata;
  assign bus.o_sram_dq_oe = r_acc == A_W1 || r_acc == A_W2;
  assign bus.o_sram_ce_n  = r_acc == A_IDLE;
  assign bus.o_sram_we_n  = r_acc != A_W1;
  assign bus.o_sram_oe_n  = !(r_acc == A_R1 || r_acc == A_R2 || r_acc == A_R3);
  assign bus.o_sram_ub_n  = r_acc == A_IDLE;
  assign bus.o_sram_lb_n  = r_acc == A_IDLE;
endmodule

// File: tb/tb_audio_rec_ctrl.sv
// tb_audio_rec_ctrl: randomized directed bench; expected playback comes from a recorded-sample list model.
`timescale 1ns/1ps
module tb_audio_rec_ctrl;
  localparam int AW = 20, DW = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  audio_rec_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  audio_rec_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [DW-1:0] rec_q[$];
  logic [DW-1:0] last_dac = '0;
  int exp_idx[$];
  int rd_q[$];
  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0] mem [int];
  logic prev_oe_n = 1'b1;

  // SRAM device model plus bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!bus.o_sram_ce_n && !bus.o_sram_we_n) begin
      mem[int'(bus.o_sram_addr)] = bus.o_sram_wdata;
      wr_q.push_back({bus.o_sram_addr, bus.o_sram_wdata});
    end
    if (!bus.o_sram_ce_n && !bus.o_sram_oe_n && prev_oe_n) rd_q.push_back(int'(bus.o_sram_addr));
    bus.i_sram_rdata = (!bus.o_sram_ce_n && !bus.o_sram_oe_n && mem.exists(int'(bus.o_sram_addr)))
                       ? mem[int'(bus.o_sram_addr)] : '0;
    prev_oe_n = bus.o_sram_oe_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int b);
    bus.i_play_btn = (b & 1) != 0;
    bus.i_stop_btn = (b & 2) != 0;
    bus.i_record_btn = (b & 4) != 0;
    tick();
    bus.i_play_btn = 1'b0;
    bus.i_stop_btn = 1'b0;
    bus.i_record_btn = 1'b0;
  endtask

  task automatic do_write(input logic [DW-1:0] d, input bit tm);
    int a = rec_q.size();
    bus.i_adc_valid = 1'b1;
    bus.i_adc_data = d;
    tick();
    bus.i_adc_valid = 1'b0;
    if (tm) begin
      chk("w1_we_n", bus.o_sram_we_n, 0);
      chk("w1_ce_n", bus.o_sram_ce_n, 0);
      chk("w1_ub_n", bus.o_sram_ub_n, 0);
      chk("w1_dq_oe", bus.o_sram_dq_oe, 1);
      chk("w1_addr", bus.o_sram_addr, a);
      chk("w1_wdata", bus.o_sram_wdata, d);
    end
    tick();
    if (tm) begin
      chk("w2_we_n", bus.o_sram_we_n, 1);
      chk("w2_ce_n", bus.o_sram_ce_n, 0);
      chk("w2_dq_oe", bus.o_sram_dq_oe, 1);
    end
    tick();
    if (tm) begin
      chk("wi_ce_n", bus.o_sram_ce_n, 1);
      chk("wi_dq_oe", bus.o_sram_dq_oe, 0);
      chk("wi_addr", bus.o_sram_addr, a + 1);
    end
    rec_q.push_back(d);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic end_rec();
    pulse(2);
    chk("rec_state", bus.o_state, 1);
    chk("end_addr", bus.o_end_addr, rec_q.size());
    chk("wr_cnt", wr_q.size(), rec_q.size());
    foreach (rec_q[i]) chk("wr_log", (i < wr_q.size()) ? wr_q[i] : '1, {AW'(i), rec_q[i]});
  endtask

  task automatic do_read(input int idx);
    bus.i_dac_req = 1'b1;
    tick();
    bus.i_dac_req = 1'b0;
    tick();
    tick();
    chk("dac_early", bus.o_dac_data, last_dac);
    tick();
    chk("dac_data", bus.o_dac_data, rec_q[idx]);
    last_dac = rec_q[idx];
    chk("rd_addr", (rd_q.size() != 0) ? rd_q.pop_front() : -1, idx);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic play_run(input logic [3:0] sw);
    int f = int'(sw[2:0]) + 1;
    exp_idx.delete();
    if (sw[3]) for (int i = 0; i < rec_q.size(); i++) repeat (f) exp_idx.push_back(i);
    else for (int i = 0; i < rec_q.size(); i += f) exp_idx.push_back(i);
`ifdef PLAY_LOOP_EN
    exp_idx.push_back(0);
`endif
    bus.i_speed_sw = sw;
    rd_q.delete();
    pulse(1);
    chk("play_state", bus.o_state, 3);
    foreach (exp_idx[k]) do_read(exp_idx[k]);
`ifdef PLAY_LOOP_EN
    pulse(2);
`endif
    chk("play_end_state", bus.o_state, 1);
  endtask

  initial begin
    bus.i_init_done = 1'b0;
    bus.i_play_btn = 1'b0;
    bus.i_stop_btn = 1'b0;
    bus.i_record_btn = 1'b0;
    bus.i_speed_sw = 4'd0;
    bus.i_adc_valid = 1'b0;
    bus.i_adc_data = '0;
    bus.i_dac_req = 1'b0;
    repeat (2) tick();
    chk("rst_state", bus.o_state, 0);
    chk("rst_strobes", {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n, bus.o_sram_ub_n, bus.o_sram_lb_n}, 5'h1f);
    chk("rst_dq_oe", bus.o_sram_dq_oe, 0);
    chk("rst_addr", bus.o_sram_addr, 0);
    chk("rst_wdata", bus.o_sram_wdata, 0);
    chk("rst_dac", bus.o_dac_data, 0);
    chk("rst_end", bus.o_end_addr, 0);
    chk("rst_ovr", bus.o_overrun, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse($urandom_range(0, 7));
      chk("init_state", bus.o_state, 0);
      chk("init_ce_n", bus.o_sram_ce_n, 1);
    end
    bus.i_init_done = 1'b1;
    tick();
    chk("init_done", bus.o_state, 1);
    pulse(1);
    chk("play_empty", bus.o_state, 1);
    chk("play_empty_rd", rd_q.size(), 0);

    pulse(4);
    chk("rec_state", bus.o_state, 2);
    for (int i = 1; i <= 5; i++) begin
      do_write(16'(i * 16'h1111), i == 1);
      if (i == 3) begin
        pulse(1);
        chk("rec_ign_play", bus.o_state, 2);
      end
    end
    end_rec();
    play_run(4'b0000);
    play_run(4'b0001);
    play_run(4'b1001);

    rec_q.delete();
    wr_q.delete();
    pulse(4);
    repeat ($urandom_range(6, 12)) do_write(16'($urandom_range(0, 16'hffff)), 1'b0);
    end_rec();
    play_run(4'($urandom_range(0, 15)));
    play_run(4'($urandom_range(0, 15)));

    bus.i_speed_sw = 4'd0;
    pulse(1);
    do_read(0);
    do_read(1);
    pulse(1);
    chk("pause_state", bus.o_state, 4);
    for (int i = 0; i < 20; i++) begin
      bus.i_dac_req = 1'b1;
      tick();
      bus.i_dac_req = 1'b0;
      chk("pause_ovr", bus.o_overrun, 0);
      repeat (4) tick();
    end
    chk("pause_no_rd", rd_q.size(), 0);
    chk("pause_dac", bus.o_dac_data, last_dac);
    pulse(1);
    chk("resume_state", bus.o_state, 3);
    do_read(2);
    pulse(2);
    chk("pause_stop", bus.o_state, 1);

    pulse(1);
    rd_q.delete();
    bus.i_dac_req = 1'b1;
    tick();
    bus.i_dac_req = 1'b0;
    bus.i_stop_btn = 1'b1;
    bus.i_play_btn = 1'b1;
    tick();
    bus.i_stop_btn = 1'b0;
    bus.i_play_btn = 1'b0;
    chk("stop_busy_state", bus.o_state, 3);
    tick();
    tick();
    chk("stop_busy_dac", bus.o_dac_data, rec_q[0]);
    last_dac = rec_q[0];
    tick();
    chk("stop_wins", bus.o_state, 1);

    rec_q.delete();
    wr_q.delete();
    pulse(4);
    bus.i_adc_valid = 1'b1;
    bus.i_adc_data = 16'hA5A5;
    tick();
    bus.i_adc_data = 16'h5A5A;
    tick();
    bus.i_adc_valid = 1'b0;
    chk("ovr_pulse", bus.o_overrun, 1);
    tick();
    chk("ovr_clear", bus.o_overrun, 0);
    chk("ovr_addr", bus.o_sram_addr, 1);
    rec_q.push_back(16'hA5A5);
    end_rec();

    pulse(4);
    bus.i_adc_valid = 1'b1;
    bus.i_adc_data = 16'h7777;
    tick();
    bus.i_adc_valid = 1'b0;
    chk("mid_we_n", bus.o_sram_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n, bus.o_sram_ub_n, bus.o_sram_lb_n}, 5'h1f);
    chk("arst_dq_oe", bus.o_sram_dq_oe, 0);
    chk("arst_state", bus.o_state, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
